// File: rtl/pcm_rom_sched.sv
// Sample ROM access scheduler: arbitrates two PCM channels and a host readback onto
// one external ROM port with a fixed ADDR/WAIT/DATA access sequence.
module pcm_rom_sched #(
    parameter int ROM_WAIT = 1,
    parameter int HOST_MAX = 4
) (
    input  logic        CLK,
    input  logic        NRES,
    input  logic        A_REQ,
    input  logic [16:0] A_ADDR,
    output logic        A_ACK,
    output logic [7:0]  A_DATA,
    input  logic        B_REQ,
    input  logic [16:0] B_ADDR,
    output logic        B_ACK,
    output logic [7:0]  B_DATA,
    input  logic        H_REQ,
    input  logic [16:0] H_ADDR,
    output logic        H_ACK,
    output logic [7:0]  H_DATA,
    output logic [16:0] SA,
    output logic        NSOE,
    input  logic [7:0]  RAM,
    output logic        BUSY
);

    typedef enum logic [1:0] {StIdle, StAddr, StWait, StData} state_e;
    typedef enum logic [1:0] {GntA, GntB, GntH} grant_e;

    state_e      state_q, state_d;
    grant_e      grant_q, grant_d;
    logic [16:0] sa_q, sa_d;
    logic        nsoe_q, nsoe_d;
    logic        busy_q, busy_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d, h_ack_q, h_ack_d;
    logic [7:0]  a_data_q, a_data_d, b_data_q, b_data_d, h_data_q, h_data_d;
    logic        last_q, last_d;  // 1: channel B was served last
    logic [3:0]  hwait_q, hwait_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;

    logic a_elig, b_elig, h_elig, host_force, chan_grant, host_grant;

    // A requester whose ACK is showing this cycle is not yet asking again.
    assign a_elig     = A_REQ && !a_ack_q;
    assign b_elig     = B_REQ && !b_ack_q;
    assign h_elig     = H_REQ && !h_ack_q;
    assign host_force = h_elig && (hwait_q >= 4'(HOST_MAX));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sa_d       = sa_q;
        nsoe_d     = nsoe_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        h_ack_d    = 1'b0;
        a_data_d   = a_data_q;
        b_data_d   = b_data_q;
        h_data_d   = h_data_q;
        last_d     = last_q;
        hwait_d    = hwait_q;
        wait_cnt_d = wait_cnt_q;
        chan_grant = 1'b0;
        host_grant = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (host_force) begin
                    host_grant = 1'b1;
                    grant_d    = GntH;
                    sa_d       = H_ADDR;
                end else if (a_elig && (!b_elig || last_q)) begin
                    chan_grant = 1'b1;
                    grant_d    = GntA;
                    sa_d       = A_ADDR;
                    last_d     = 1'b0;
                end else if (b_elig) begin
                    chan_grant = 1'b1;
                    grant_d    = GntB;
                    sa_d       = B_ADDR;
                    last_d     = 1'b1;
                end else if (h_elig) begin
                    host_grant = 1'b1;
                    grant_d    = GntH;
                    sa_d       = H_ADDR;
                end
                if (chan_grant || host_grant) begin
                    state_d = StAddr;
                    nsoe_d  = 1'b0;
                end
            end
            StAddr: begin
                if (ROM_WAIT == 0) begin
                    state_d = StData;
                end else begin
                    state_d    = StWait;
                    wait_cnt_d = 2'(ROM_WAIT - 1);
                end
            end
            StWait: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = StData;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            StData: begin
                state_d = StIdle;
                nsoe_d  = 1'b1;
                unique case (grant_q)
                    GntA: begin
                        a_ack_d  = 1'b1;
                        a_data_d = RAM;
                    end
                    GntB: begin
                        b_ack_d  = 1'b1;
                        b_data_d = RAM;
                    end
                    default: begin
                        h_ack_d  = 1'b1;
                        h_data_d = RAM;
                    end
                endcase
            end
            default: state_d = StIdle;
        endcase

        if (!H_REQ || host_grant) begin
            hwait_d = 4'd0;
        end else if (chan_grant && (hwait_q != 4'hF)) begin
            hwait_d = hwait_q + 4'd1;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            state_q    <= StIdle;
            grant_q    <= GntA;
            sa_q       <= 17'd0;
            nsoe_q     <= 1'b1;
            busy_q     <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            h_ack_q    <= 1'b0;
            a_data_q   <= 8'h00;
            b_data_q   <= 8'h00;
            h_data_q   <= 8'h00;
            last_q     <= 1'b1;
            hwait_q    <= 4'd0;
            wait_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sa_q       <= sa_d;
            nsoe_q     <= nsoe_d;
            busy_q     <= busy_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            h_ack_q    <= h_ack_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            h_data_q   <= h_data_d;
            last_q     <= last_d;
            hwait_q    <= hwait_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign SA     = sa_q;
    assign NSOE   = nsoe_q;
    assign BUSY   = busy_q;
    assign A_ACK  = a_ack_q;
    assign B_ACK  = b_ack_q;
    assign H_ACK  = h_ack_q;
    assign A_DATA = a_data_q;
    assign B_DATA = b_data_q;
    assign H_DATA = h_data_q;

endmodule

// File: tb/tb_pcm_rom_sched.sv
// Directed bench for pcm_rom_sched: one instance at ROM_WAIT=1/HOST_MAX=4, one at ROM_WAIT=0.
module tb_pcm_rom_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nres;
    logic        a_req, b_req, h_req;
    logic [16:0] a_addr, b_addr, h_addr;
    logic        a_ack, b_ack, h_ack, nsoe, busy;
    logic [7:0]  a_data, b_data, h_data, ram;
    logic [16:0] sa;

    logic        b0_req;
    logic [16:0] b0_addr;
    logic        zero_req;
    logic [16:0] zero_addr;
    logic        a0_ack, b0_ack, h0_ack, nsoe0, busy0;
    logic [7:0]  a0_data, b0_data, h0_data, ram0;
    logic [16:0] sa0;

    // ROM model: one fixed location returns 0x5A, everything else returns its low address byte.
    assign ram  = (sa == 17'h1ABCD) ? 8'h5A : sa[7:0];
    assign ram0 = sa0[7:0];

    pcm_rom_sched #(.ROM_WAIT(1), .HOST_MAX(4)) dut1 (
        .CLK(clk), .NRES(nres),
        .A_REQ(a_req), .A_ADDR(a_addr), .A_ACK(a_ack), .A_DATA(a_data),
        .B_REQ(b_req), .B_ADDR(b_addr), .B_ACK(b_ack), .B_DATA(b_data),
        .H_REQ(h_req), .H_ADDR(h_addr), .H_ACK(h_ack), .H_DATA(h_data),
        .SA(sa), .NSOE(nsoe), .RAM(ram), .BUSY(busy)
    );

    pcm_rom_sched #(.ROM_WAIT(0), .HOST_MAX(4)) dut0 (
        .CLK(clk), .NRES(nres),
        .A_REQ(zero_req), .A_ADDR(zero_addr), .A_ACK(a0_ack), .A_DATA(a0_data),
        .B_REQ(b0_req), .B_ADDR(b0_addr), .B_ACK(b0_ack), .B_DATA(b0_data),
        .H_REQ(zero_req), .H_ADDR(zero_addr), .H_ACK(h0_ack), .H_DATA(h0_data),
        .SA(sa0), .NSOE(nsoe0), .RAM(ram0), .BUSY(busy0)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ev_who[$];
    int ev_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Steps n cycles and logs every ACK of dut1 as (who, cycle): 0=A, 1=B, 2=H.
    task automatic run_log(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (a_ack) begin ev_who.push_back(0); ev_cyc.push_back(cyc); end
            if (b_ack) begin ev_who.push_back(1); ev_cyc.push_back(cyc); end
            if (h_ack) begin ev_who.push_back(2); ev_cyc.push_back(cyc); end
        end
    endtask

    task automatic check_events(input string tag, input int who[], input int at[]);
        check({tag, "_count"}, ev_who.size(), who.size());
        for (int i = 0; i < who.size() && i < ev_who.size(); i++) begin
            check($sformatf("%s_who%0d", tag, i), ev_who[i], who[i]);
            check($sformatf("%s_cyc%0d", tag, i), ev_cyc[i], at[i]);
        end
    endtask

    task automatic reset_hold();
        nres   = 1'b0;
        a_req  = 1'b0;
        b_req  = 1'b0;
        h_req  = 1'b0;
        b0_req = 1'b0;
        step();
        step();
    endtask

    // Release reset; the cycle that follows is cycle 0, the first arbitration cycle.
    task automatic release_reset();
        nres = 1'b1;
        cyc  = 0;
        ev_who.delete();
        ev_cyc.delete();
    endtask

    initial begin
        zero_req  = 1'b0;
        zero_addr = 17'd0;
        a_addr    = 17'd0;
        b_addr    = 17'd0;
        h_addr    = 17'd0;
        b0_addr   = 17'd0;
        #1;
        reset_hold();

        check("rst_sa", 32'(sa), 32'h0);
        check("rst_nsoe", 32'(nsoe), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_acks", {29'd0, a_ack, b_ack, h_ack}, 32'h0);
        check("rst_data", {8'd0, a_data, b_data, h_data}, 32'h0);
        check("rst_last_b", 32'(dut1.last_q), 32'h1);
        check("rst_hwait", 32'(dut1.hwait_q), 32'h0);

        // Single A access, address changed after grant must not matter.
        a_req  = 1'b1;
        a_addr = 17'h1ABCD;
        release_reset();
        check("single_idle_busy", 32'(busy), 32'h0);
        step();
        check("single_sa", 32'(sa), 32'h1ABCD);
        check("single_nsoe1", 32'(nsoe), 32'h0);
        check("single_busy", 32'(busy), 32'h1);
        a_addr = 17'h00000;
        step();
        check("single_nsoe2", 32'(nsoe), 32'h0);
        check("single_sa_hold", 32'(sa), 32'h1ABCD);
        step();
        check("single_nsoe3", 32'(nsoe), 32'h0);
        check("single_noack3", 32'(a_ack), 32'h0);
        step();
        check("single_ack", 32'(a_ack), 32'h1);
        check("single_data", 32'(a_data), 32'h5A);
        check("single_nsoe_hi", 32'(nsoe), 32'h1);
        a_req = 1'b0;
        step();
        check("single_ack_pulse", 32'(a_ack), 32'h0);
        check("single_idle", 32'(busy), 32'h0);
        check("single_sa_idle", 32'(sa), 32'h1ABCD);
        check("single_data_hold", 32'(a_data), 32'h5A);

        // Round-robin between A and B.
        reset_hold();
        a_addr = 17'h00011;
        b_addr = 17'h00022;
        a_req  = 1'b1;
        b_req  = 1'b1;
        release_reset();
        run_log(17);
        check_events("rr", '{0, 1, 0, 1}, '{4, 8, 12, 16});
        check("rr_a_data", 32'(a_data), 32'h11);
        check("rr_b_data", 32'(b_data), 32'h22);

        // Host starvation guard.
        reset_hold();
        h_addr = 17'h00033;
        a_req  = 1'b1;
        b_req  = 1'b1;
        h_req  = 1'b1;
        release_reset();
        run_log(16);
        check("host_hwait4", 32'(dut1.hwait_q), 32'h4);
        run_log(4);
        check_events("host", '{0, 1, 0, 1, 2}, '{4, 8, 12, 16, 20});
        check("host_data", 32'(h_data), 32'h33);
        check("host_hwait0", 32'(dut1.hwait_q), 32'h0);
        check("host_last_kept", 32'(dut1.last_q), 32'h1);

        // Reset during WAIT aborts; held request is served after release, then again.
        reset_hold();
        a_addr = 17'h00044;
        a_req  = 1'b1;
        release_reset();
        step();
        step();
        check("abort_in_wait", 32'(nsoe), 32'h0);
        #1 nres = 1'b0;
        #1;
        check("abort_nsoe", 32'(nsoe), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_data", 32'(a_data), 32'h00);
        step();
        check("abort_noack1", 32'(a_ack), 32'h0);
        step();
        check("abort_noack2", 32'(a_ack), 32'h0);
        check("abort_data2", 32'(a_data), 32'h00);
        release_reset();
        run_log(9);
        check_events("held", '{0, 0}, '{4, 9});
        check("held_data", 32'(a_data), 32'h44);

        // ROM_WAIT=0 instance, lone B request.
        reset_hold();
        b0_addr = 17'h00055;
        b0_req  = 1'b1;
        release_reset();
        step();
        check("rw0_nsoe1", 32'(nsoe0), 32'h0);
        check("rw0_sa", 32'(sa0), 32'h00055);
        step();
        check("rw0_nsoe2", 32'(nsoe0), 32'h0);
        check("rw0_noack", 32'(b0_ack), 32'h0);
        step();
        check("rw0_ack", 32'(b0_ack), 32'h1);
        check("rw0_nsoe_hi", 32'(nsoe0), 32'h1);
        check("rw0_data", 32'(b0_data), 32'h55);
        b0_req = 1'b0;
        step();
        check("rw0_ack_pulse", 32'(b0_ack), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
